// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET, emits one
// CSR write strobe, then holds a PC redirect until fetch accepts it.
module trap_ctrl #(
  parameter int TRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exc_valid,
  input  logic [3:0]            exc_cause,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_tval,
  input  logic                  mret_req,
  input  logic                  int_ok,
  input  logic [31:0]           int_pc,
  input  logic                  msip,
  input  logic                  mtip,
  input  logic                  meip,
  input  logic                  msie,
  input  logic                  mtie,
  input  logic                  meie,
  input  logic                  mie,
  input  logic                  mpie,
  input  logic [29:0]           mtvec_base,
  input  logic [31:0]           mepc,
  output logic                  csr_we,
  output logic [31:0]           mepc_wd,
  output logic [31:0]           mcause_wd,
  output logic [31:0]           mtval_wd,
  output logic                  mie_wd,
  output logic                  mpie_wd,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready,
  output logic [TRAP_CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIRECT} state_t;

  state_t                  state, state_next;
  logic [31:0]             target, target_next;
  logic                    csr_we_next, busy_next, redirect_valid_next;
  logic [31:0]             mepc_wd_next, mcause_wd_next, mtval_wd_next, redirect_pc_next;
  logic                    mie_wd_next, mpie_wd_next;
  logic [TRAP_CNT_W-1:0]   trap_count_next;
  logic [3:0]              cause_legal;
  logic                    irq_take;
  logic [31:0]             irq_cause;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{exc_pc[1:0], int_pc[1:0]};

  always_comb begin
    case (exc_cause)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11: cause_legal = exc_cause;
      default: cause_legal = 4'd2;
    endcase
  end

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    irq_take  = int_ok & mie & ((meip & meie) | (msip & msie) | (mtip & mtie));
    if (meip & meie)      irq_cause = 32'h8000_000B;
    else if (msip & msie) irq_cause = 32'h8000_0003;
    else                  irq_cause = 32'h8000_0007;
  end

  always_comb begin
    state_next          = state;
    target_next         = target;
    csr_we_next         = 1'b0;
    mepc_wd_next        = mepc_wd;
    mcause_wd_next      = mcause_wd;
    mtval_wd_next       = mtval_wd;
    mie_wd_next         = mie_wd;
    mpie_wd_next        = mpie_wd;
    redirect_valid_next = redirect_valid;
    redirect_pc_next    = redirect_pc;
    trap_count_next     = trap_count;

    unique case (state)
      IDLE: begin
        if (exc_valid) begin
          state_next      = ENTER;
          csr_we_next     = 1'b1;
          mepc_wd_next    = {exc_pc[31:2], 2'b00};
          mcause_wd_next  = {28'b0, cause_legal};
          mtval_wd_next   = exc_tval;
          mpie_wd_next    = mie;
          mie_wd_next     = 1'b0;
          target_next     = {mtvec_base, 2'b00};
          trap_count_next = (&trap_count) ? trap_count : trap_count + TRAP_CNT_W'(1);
        end else if (mret_req) begin
          // mcause/mtval keep the values captured at entry, so they are rewritten unchanged.
          state_next      = RETURN;
          csr_we_next     = 1'b1;
          mepc_wd_next    = mepc;
          mie_wd_next     = mpie;
          mpie_wd_next    = 1'b1;
          target_next     = {mepc[31:2], 2'b00};
        end else if (irq_take) begin
          state_next      = ENTER;
          csr_we_next     = 1'b1;
          mepc_wd_next    = {int_pc[31:2], 2'b00};
          mcause_wd_next  = irq_cause;
          mtval_wd_next   = 32'b0;
          mpie_wd_next    = mie;
          mie_wd_next     = 1'b0;
          target_next     = {mtvec_base, 2'b00};
          trap_count_next = (&trap_count) ? trap_count : trap_count + TRAP_CNT_W'(1);
        end
      end
      ENTER, RETURN: begin
        state_next          = REDIRECT;
        redirect_valid_next = 1'b1;
        redirect_pc_next    = target;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_next          = IDLE;
          redirect_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      target         <= '0;
      csr_we         <= 1'b0;
      mepc_wd        <= '0;
      mcause_wd      <= '0;
      mtval_wd       <= '0;
      mie_wd         <= 1'b0;
      mpie_wd        <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_count     <= '0;
    end else begin
      state          <= state_next;
      target         <= target_next;
      csr_we         <= csr_we_next;
      mepc_wd        <= mepc_wd_next;
      mcause_wd      <= mcause_wd_next;
      mtval_wd       <= mtval_wd_next;
      mie_wd         <= mie_wd_next;
      mpie_wd        <= mpie_wd_next;
      busy           <= busy_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
      trap_count     <= trap_count_next;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a phase-level model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_trap_ctrl;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_valid = 0, mret_req = 0, int_ok = 0, redirect_ready = 0;
  logic [3:0]  exc_cause = 0;
  logic [31:0] exc_pc = 0, exc_tval = 0, int_pc = 0, mepc = 0;
  logic        msip = 0, mtip = 0, meip = 0, msie = 0, mtie = 0, meie = 0, mie = 0, mpie = 0;
  logic [29:0] mtvec_base = 0;
  logic        csr_we, mie_wd, mpie_wd, busy, redirect_valid;
  logic [31:0] mepc_wd, mcause_wd, mtval_wd, redirect_pc;
  logic [CW-1:0] trap_count;

  always #5 clk = ~clk;

  trap_ctrl #(.TRAP_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .int_ok(int_ok), .int_pc(int_pc),
    .msip(msip), .mtip(mtip), .meip(meip), .msie(msie), .mtie(mtie), .meie(meie),
    .mie(mie), .mpie(mpie), .mtvec_base(mtvec_base), .mepc(mepc),
    .csr_we(csr_we), .mepc_wd(mepc_wd), .mcause_wd(mcause_wd), .mtval_wd(mtval_wd),
    .mie_wd(mie_wd), .mpie_wd(mpie_wd), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_count(trap_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0: waiting for an event, 1: CSR write cycle, 2: redirect outstanding.
  int          m_ph;
  int          m_cnt;
  logic [31:0] m_mepc, m_mcause, m_mtval, m_tgt;
  logic        m_mie, m_mpie;

  function automatic logic [31:0] legal_cause(input logic [3:0] c);
    return (c <= 4'd7 || c == 4'd11) ? {28'b0, c} : 32'd2;
  endfunction

  function automatic logic [31:0] pending_irq();
    if (!(int_ok && mie)) return 32'd0;
    if (meip && meie) return 32'h8000_000B;
    if (msip && msie) return 32'h8000_0003;
    if (mtip && mtie) return 32'h8000_0007;
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_cnt <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_tgt <= 0; m_mie <= 0; m_mpie <= 0;
    end else if (m_ph == 0) begin
      if (exc_valid) begin
        m_ph <= 1; m_mepc <= exc_pc & 32'hFFFF_FFFC; m_mcause <= legal_cause(exc_cause);
        m_mtval <= exc_tval; m_mpie <= mie; m_mie <= 1'b0; m_tgt <= {mtvec_base, 2'b00};
        m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (mret_req) begin
        m_ph <= 1; m_mepc <= mepc; m_mie <= mpie; m_mpie <= 1'b1; m_tgt <= mepc & 32'hFFFF_FFFC;
      end else if (pending_irq() != 0) begin
        m_ph <= 1; m_mepc <= int_pc & 32'hFFFF_FFFC; m_mcause <= pending_irq();
        m_mtval <= 0; m_mpie <= mie; m_mie <= 1'b0; m_tgt <= {mtvec_base, 2'b00};
        m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end else if (m_ph == 1) begin
      m_ph <= 2;
    end else if (redirect_ready) begin
      m_ph <= 0;
    end
  end

  always @(negedge clk) begin
    check("csr_we", 32'(csr_we), 32'(m_ph == 1));
    check("busy", 32'(busy), 32'(m_ph != 0));
    check("redirect_valid", 32'(redirect_valid), 32'(m_ph == 2));
    check("trap_count", 32'(trap_count), 32'(m_cnt));
    if (m_ph == 1) begin
      check("mepc_wd", mepc_wd, m_mepc);
      check("mcause_wd", mcause_wd, m_mcause);
      check("mtval_wd", mtval_wd, m_mtval);
      check("mie_wd", 32'(mie_wd), 32'(m_mie));
      check("mpie_wd", 32'(mpie_wd), 32'(m_mpie));
    end
    if (m_ph == 2) check("redirect_pc", redirect_pc, m_tgt);
  end

  // ---------------- directed stimulus ----------------
  task automatic quiet();
    exc_valid = 0; mret_req = 0; int_ok = 0; meip = 0; msip = 0; mtip = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive an interrupt set, then check the write cycle and let the redirect finish.
  task automatic irq_case(input string tag, input logic e, input logic s, input logic t,
                          input logic [31:0] exp_cause);
    quiet(); meip = e; msip = s; mtip = t; meie = 1; msie = 1; mtie = 1;
    mie = 1; int_ok = 1; int_pc = 32'h200; redirect_ready = 1;
    step();
    check({tag, "_we"}, 32'(csr_we), 32'd1);
    check({tag, "_cause"}, mcause_wd, exp_cause);
    check({tag, "_mepc"}, mepc_wd, 32'h200);
    check({tag, "_mtval"}, mtval_wd, 32'h0);
    quiet();
    step(); step();
    $display("[TB] %s interrupt: mcause_wd=0x%08h", tag, exp_cause);
  endtask

  initial begin
    mtvec_base = 30'h20;
    repeat (2) step();
    check("rst_csr_we", 32'(csr_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_mcause", mcause_wd, 32'd0);
    check("rst_count", 32'(trap_count), 32'd0);
    rst_n = 1;

    // Exception, cause 11
    exc_valid = 1; exc_cause = 4'd11; exc_pc = 32'h104; exc_tval = 32'h55; mie = 1;
    step();
    check("exc_we", 32'(csr_we), 32'd1);
    check("exc_mepc", mepc_wd, 32'h104);
    check("exc_cause", mcause_wd, 32'hB);
    check("exc_tval", mtval_wd, 32'h55);
    check("exc_mpie", 32'(mpie_wd), 32'd1);
    check("exc_mie", 32'(mie_wd), 32'd0);
    exc_valid = 0; redirect_ready = 1;
    step();
    check("exc_rv", 32'(redirect_valid), 32'd1);
    check("exc_rpc", redirect_pc, 32'h80);
    step();
    check("exc_done", 32'(busy), 32'd0);
    $display("[TB] exception cause 11 -> redirect 0x80");

    // Illegal cause and misaligned PC
    exc_valid = 1; exc_cause = 4'd9; exc_pc = 32'h107; exc_tval = 32'hDEAD;
    step();
    check("ill_cause", mcause_wd, 32'h2);
    check("ill_mepc", mepc_wd, 32'h104);
    exc_valid = 0;
    step(); step();
    $display("[TB] exception cause 9 -> encoded as 2");

    irq_case("mei", 1, 0, 1, 32'h8000_000B);
    irq_case("msi", 0, 1, 1, 32'h8000_0003);
    irq_case("mti", 0, 0, 1, 32'h8000_0007);

    // Exception and MRET together: exception wins
    exc_valid = 1; mret_req = 1; exc_cause = 4'd5; exc_pc = 32'h400; exc_tval = 32'h77;
    mie = 1; mpie = 1;
    step();
    check("pri_cause", mcause_wd, 32'h5);
    check("pri_mie", 32'(mie_wd), 32'd0);
    check("pri_count", 32'(trap_count), 32'd6);
    quiet();
    step(); step();
    $display("[TB] exception+mret -> exception taken");

    // MRET with fetch stalled for three cycles
    mret_req = 1; mpie = 1; mie = 0; mepc = 32'h300; redirect_ready = 0;
    step();
    check("mret_we", 32'(csr_we), 32'd1);
    check("mret_mie", 32'(mie_wd), 32'd1);
    check("mret_mpie", 32'(mpie_wd), 32'd1);
    check("mret_mepc", mepc_wd, 32'h300);
    check("mret_cause", mcause_wd, 32'h5);
    check("mret_tval", mtval_wd, 32'h77);
    mret_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mret_hold_rv", 32'(redirect_valid), 32'd1);
      check("mret_hold_rpc", redirect_pc, 32'h300);
    end
    redirect_ready = 1;
    step();
    check("mret_done", 32'(redirect_valid), 32'd0);
    check("mret_count", 32'(trap_count), 32'd6);
    $display("[TB] mret -> redirect 0x300 after stall");

    // Pending interrupt masked by mie, then by int_ok
    meip = 1; meie = 1; mie = 0; int_ok = 1;
    repeat (4) begin step(); check("mask_mie_busy", 32'(busy), 32'd0); end
    mie = 1; int_ok = 0;
    repeat (4) begin step(); check("mask_ok_busy", 32'(busy), 32'd0); end
    quiet();
    $display("[TB] masked interrupts ignored");

    // Back-to-back exceptions until the counter saturates
    exc_valid = 1; exc_cause = 4'd1; exc_pc = 32'h500; redirect_ready = 1;
    repeat (45) step();
    exc_valid = 0;
    step(); step(); step();
    check("sat_count", 32'(trap_count), 32'(CNT_MAX));
    $display("[TB] back-to-back traps -> trap_count saturated");

    // Reset during REDIRECT
    exc_valid = 1; redirect_ready = 0;
    step();
    exc_valid = 0;
    step();
    check("rr_rv_before", 32'(redirect_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("rr_rv", 32'(redirect_valid), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_count", 32'(trap_count), 32'd0);
    step();
    rst_n = 1; redirect_ready = 1;
    exc_valid = 1; exc_cause = 4'd3; exc_pc = 32'h600;
    step();
    check("post_rst_we", 32'(csr_we), 32'd1);
    check("post_rst_cause", mcause_wd, 32'h3);
    check("post_rst_count", 32'(trap_count), 32'd1);
    exc_valid = 0;
    repeat (4) step();
    $display("[TB] reset during redirect aborts, first edge after release samples");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: TRAP_CNT_W, default 16, width of the trap_count counter.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 exc_valid  input  1  synchronous exception raised by the retiring instruction.
REQ-006 exc_cause  input  4  exception code: 0,1,2,3,4,5,6,7 or 11.
REQ-007 exc_pc  input  32  PC of the faulting instruction.
REQ-008 exc_tval  input  32  trap value for the exception.
REQ-009 mret_req  input  1  the retiring instruction is MRET.
REQ-010 int_ok  input  1  the pipeline is at an instruction boundary where an interrupt may be taken.
REQ-011 int_pc  input  32  PC of the next instruction to execute (saved on interrupt).
REQ-012 msip, mtip, meip  input  1 each  pending interrupt lines.
REQ-013 msie, mtie, meie, mie, mpie  input  1 each  current CSR enable and status bits.
REQ-014 mtvec_base  input  30  trap vector base [31:2]; direct mode only.
REQ-015 mepc  input  32  current MEPC value.
REQ-016 csr_we  output  1  one-cycle strobe that commits all *_wd outputs into the CSR file.
REQ-017 mepc_wd, mcause_wd, mtval_wd  output  32 each  CSR write data.
REQ-018 mie_wd, mpie_wd  output  1 each  mstatus write data.
REQ-019 busy  output  1  high while state != IDLE; pipeline stalls and holds its inputs.
REQ-020 redirect_valid  output  1  PC redirect request.
REQ-021 redirect_pc  output  32  redirect target PC.
REQ-022 redirect_ready  input  1  fetch accepts the redirect.
REQ-023 trap_count  output  TRAP_CNT_W  number of traps taken, saturating.

Function
REQ-024 States SHALL be IDLE, ENTER, RETURN and REDIRECT; all outputs SHALL be registered.
REQ-025 Events SHALL be sampled only in IDLE; all inputs SHALL be ignored in every other state.
REQ-026 In IDLE, event priority SHALL be: exc_valid, then mret_req, then interrupt.
- An interrupt requires int_ok && mie && (meip&meie | msip&msie | mtip&mtie).
REQ-027 Among pending enabled interrupts, priority SHALL be MEI, then MSI, then MTI.
REQ-028 Exception event: IDLE->ENTER; next cycle csr_we=1 with:
- mepc_wd = {exc_pc[31:2],2'b00}
- mcause_wd = {28'b0, exc_cause}
- mtval_wd = exc_tval
- mpie_wd = mie, mie_wd = 0
REQ-029 Interrupt event: IDLE->ENTER; next cycle csr_we=1 with:
- mepc_wd = {int_pc[31:2],2'b00}, mtval_wd = 0
- mcause_wd = 0x8000000B (MEI), 0x80000003 (MSI) or 0x80000007 (MTI)
- mpie_wd = mie, mie_wd = 0
REQ-030 MRET event: IDLE->RETURN; next cycle csr_we=1 with:
- mie_wd = mpie, mpie_wd = 1
- mepc_wd, mcause_wd and mtval_wd echo the current CSR values (mepc input; mcause and mtval as captured at entry).
REQ-031 ENTER->REDIRECT with redirect_pc = {mtvec_base,2'b00}.
REQ-032 RETURN->REDIRECT with redirect_pc = {mepc[31:2],2'b00}.
REQ-033 csr_we SHALL be high for exactly one cycle per trap or MRET; this is the cycle the state is ENTER or RETURN.
REQ-034 In REDIRECT, redirect_valid=1 and redirect_pc SHALL be held stable until redirect_ready=1.
- Then the FSM goes to IDLE next cycle and redirect_valid drops.
REQ-035 redirect_ready arriving in the same cycle redirect_valid first rises SHALL complete the handshake in one cycle.
REQ-036 Latency: an event sampled at edge N gives csr_we at N+1 and redirect_valid from N+2; ready at N+2 returns to IDLE at N+3.
REQ-037 busy SHALL be high in ENTER, RETURN and REDIRECT.
REQ-038 A new event SHALL NOT be accepted in the cycle the FSM returns to IDLE; it is sampled on the next edge.
REQ-039 trap_count SHALL increment by 1 on each IDLE->ENTER transition (exceptions and interrupts, not MRET) and saturate at all-ones.
REQ-040 An exc_cause outside the legal set SHALL be encoded as 2 (illegal instruction).

Reset
REQ-041 On rst_n=0, state SHALL be IDLE immediately (asynchronous) and all outputs SHALL be 0: csr_we, busy, redirect_valid, redirect_pc, *_wd, trap_count.
REQ-042 Reset asserted mid-sequence SHALL abort the sequence with no further csr_we; there is no redirect after reset release.
REQ-043 After rst_n rises, the first event SHALL be sampled at the first rising clk edge.

Verification
REQ-044 exc_valid=1, exc_cause=11, exc_pc=0x104, mie=1, mtvec_base=0x20 -> csr_we at N+1 with mepc_wd=0x104, mcause_wd=0xB, mpie_wd=1, mie_wd=0; redirect_pc=0x80.
REQ-045 meip=mtip=1, meie=mtie=1, mie=1, int_ok=1, int_pc=0x200 -> mcause_wd=0x8000000B, mepc_wd=0x200, mtval_wd=0.
REQ-046 exc_valid=1 and mret_req=1 in the same cycle -> exception taken; no MRET writes.
REQ-047 mret_req=1, mpie=1, mepc=0x300 -> mie_wd=1, mpie_wd=1; redirect_pc=0x300; redirect_ready held 0 for 3 cycles -> redirect_valid and redirect_pc remain stable throughout.
REQ-048 mip pending but mie=0, or int_ok=0 -> no trap, busy stays 0.
REQ-049 rst_n pulsed low during REDIRECT -> redirect_valid=0 immediately; 2^TRAP_CNT_W+1 traps -> trap_count stays all-ones.
